// File: rtl/tag_fifo.sv
// tag_fifo: free list of rename/ROB tags kept as a circular FIFO.
// The dispatcher takes tags from the head and retire returns them at the tail.
// Reset and flush both refill the list with every tag 0..DEPTH-1 in order.
module tag_fifo #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             flush,
  output logic [TAG_W:0]   tag_count,
  output logic             full,
  output logic             overflow_err,
  output logic             underflow_err
);

  // Initial write pointer: a full lap ahead of the read pointer.
  // The wrap bit is set and the low bits are zero.
  localparam logic [TAG_W:0] FULL_PTR = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [TAG_W:0]   rd_ptr;
  logic [TAG_W:0]   wr_ptr;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  // Occupancy flags, derived from the pointers and their wrap bits.
  always_comb begin
    empty     = (rd_ptr == wr_ptr);
    full      = (rd_ptr[TAG_W-1:0] == wr_ptr[TAG_W-1:0]) &&
                (rd_ptr[TAG_W] != wr_ptr[TAG_W]);
    tag_count = wr_ptr - rd_ptr;
  end

  // Accepted operations; flush discards anything presented with it.
  always_comb begin
    do_pop  = alloc_req && !empty && !flush;
    do_push = free_valid && !full && !flush;
  end

  // Show-ahead head tag, with no bypass from a same-cycle push.
  always_comb begin
    alloc_tag   = mem[rd_ptr[TAG_W-1:0]];
    alloc_valid = !empty;
  end

  // Pointer state: reset and flush both restore the full list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= FULL_PTR;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= FULL_PTR;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Tag storage: reset and flush reload the identity mapping.
  // Otherwise only accepted pushes write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
    end else if (do_push) begin
      mem[wr_ptr[TAG_W-1:0]] <= free_tag;
    end
  end

  // Sticky error flags.
  // Only reset clears them; flush leaves them intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (free_valid && full && !flush)  overflow_err  <= 1'b1;
      if (alloc_req && empty && !flush)  underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tag_fifo.sv
// tb_tag_fifo: directed bench for tag_fifo.
// Expected values are hand-derived, plus a small queue model for permuted returns.
module tb_tag_fifo;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic [5:0] alloc_tag;
  logic       alloc_valid;
  logic       free_valid;
  logic [5:0] free_tag;
  logic       flush;
  logic [6:0] tag_count;
  logic       full;
  logic       overflow_err;
  logic       underflow_err;

  int tests;
  int failures;
  logic [5:0] model_q [$];
  logic [5:0] next_tag;

  tag_fifo #(.TAG_W(6), .DEPTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .alloc_req(alloc_req),
    .alloc_tag(alloc_tag),
    .alloc_valid(alloc_valid),
    .free_valid(free_valid),
    .free_tag(free_tag),
    .flush(flush),
    .tag_count(tag_count),
    .full(full),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Compares one observed value against its expectation and counts the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, then samples just after the rising edge.
  task automatic applyStimulus(input logic a, input logic f, input logic [5:0] t, input logic fl);
    alloc_req  = a;
    free_valid = f;
    free_tag   = t;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks the state it forces immediately.
  task automatic doReset();
    rst = 1'b1;
    alloc_req = 1'b0; free_valid = 1'b0; free_tag = '0; flush = 1'b0;
    #1;
    checkOutput("rst_alloc_tag", 32'(alloc_tag), 0);
    checkOutput("rst_alloc_valid", 32'(alloc_valid), 1);
    checkOutput("rst_full", 32'(full), 1);
    checkOutput("rst_tag_count", 32'(tag_count), 64);
    checkOutput("rst_overflow", 32'(overflow_err), 0);
    checkOutput("rst_underflow", 32'(underflow_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    tests = 0;
    failures = 0;
    rst = 1'b0;
    alloc_req = 1'b0; free_valid = 1'b0; free_tag = '0; flush = 1'b0;
    #2;
    doReset();

    // Push while full is dropped and raises overflow.
    applyStimulus(1'b0, 1'b1, 6'd9, 1'b0);
    checkOutput("ovf_alone_count", 32'(tag_count), 64);
    checkOutput("ovf_alone_err", 32'(overflow_err), 1);
    // The same push with a pop: the pop proceeds and the push is still dropped.
    applyStimulus(1'b1, 1'b1, 6'd9, 1'b0);
    checkOutput("ovf_pop_count", 32'(tag_count), 63);
    checkOutput("ovf_pop_head", 32'(alloc_tag), 1);
    checkOutput("ovf_pop_full", 32'(full), 0);

    doReset();

    // The first three pops yield tags 0, 1, 2.
    for (int i = 0; i < 3; i++) begin
      checkOutput("first_pops_head", 32'(alloc_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    end
    checkOutput("first_pops_count", 32'(tag_count), 61);
    checkOutput("first_pops_full", 32'(full), 0);

    // Drain the remaining tags.
    for (int i = 3; i < 64; i++) begin
      checkOutput("drain_head", 32'(alloc_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    end
    checkOutput("drain_valid", 32'(alloc_valid), 0);
    checkOutput("drain_count", 32'(tag_count), 0);
    checkOutput("drain_underflow_clear", 32'(underflow_err), 0);

    // One more pop while empty raises underflow and leaves the pointers alone.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("udf_err", 32'(underflow_err), 1);
    checkOutput("udf_count", 32'(tag_count), 0);
    checkOutput("udf_valid", 32'(alloc_valid), 0);

    // A push into an empty list is not visible in the same cycle.
    alloc_req = 1'b0; free_valid = 1'b1; free_tag = 6'd5; flush = 1'b0;
    #1;
    checkOutput("nobypass_valid", 32'(alloc_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("push5_valid", 32'(alloc_valid), 1);
    checkOutput("push5_head", 32'(alloc_tag), 5);
    checkOutput("push5_count", 32'(tag_count), 1);
    model_q.push_back(6'd5);

    // Build some depth, then stream pops and pushes of permuted tags across the wrap.
    for (int k = 0; k < 6; k++) begin
      next_tag = 6'((k * 37 + 11) % 64);
      model_q.push_back(next_tag);
      applyStimulus(1'b0, 1'b1, next_tag, 1'b0);
    end
    checkOutput("stream_fill_count", 32'(tag_count), 7);
    for (int k = 6; k < 76; k++) begin
      checkOutput("stream_head", 32'(alloc_tag), 32'(model_q[0]));
      next_tag = 6'((k * 37 + 11) % 64);
      void'(model_q.pop_front());
      model_q.push_back(next_tag);
      applyStimulus(1'b1, 1'b1, next_tag, 1'b0);
      checkOutput("stream_count", 32'(tag_count), 7);
    end

    // Flush restores the full list but keeps the sticky errors.
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("flush1_count", 32'(tag_count), 64);
    checkOutput("flush1_head", 32'(alloc_tag), 0);
    checkOutput("flush1_underflow", 32'(underflow_err), 1);
    applyStimulus(1'b0, 1'b1, 6'd9, 1'b0);
    checkOutput("flush1_ovf", 32'(overflow_err), 1);

    // Pop ten tags, then flush together with a pop and a push.
    for (int i = 0; i < 10; i++) begin
      checkOutput("pop10_head", 32'(alloc_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    end
    checkOutput("pop10_count", 32'(tag_count), 54);
    applyStimulus(1'b1, 1'b1, 6'd33, 1'b1);
    checkOutput("flush2_count", 32'(tag_count), 64);
    checkOutput("flush2_head", 32'(alloc_tag), 0);
    checkOutput("flush2_full", 32'(full), 1);
    checkOutput("flush2_ovf", 32'(overflow_err), 1);
    checkOutput("flush2_udf", 32'(underflow_err), 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("post_flush_head", 32'(alloc_tag), 32'(i));
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    end
    checkOutput("post_flush_count", 32'(tag_count), 61);

    // Reset mid-operation abandons pending work immediately.
    alloc_req = 1'b1; free_valid = 1'b1; free_tag = 6'd44; flush = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_count", 32'(tag_count), 64);
    checkOutput("midrst_head", 32'(alloc_tag), 0);
    checkOutput("midrst_ovf", 32'(overflow_err), 0);
    checkOutput("midrst_udf", 32'(underflow_err), 0);
    alloc_req = 1'b0; free_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_after_count", 32'(tag_count), 64);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/tag_fifo.md
TAG_FIFO -- requirements
Module: tag_fifo

Interface
REQ-001 The module SHALL have parameter TAG_W, default 6, meaning ROB/rename tag width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 64 (2**TAG_W), meaning the number of tags managed.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port alloc_req, input, 1 bit: dispatcher consumes the head tag this cycle (dispatch_en and dispatch_need_tag).
REQ-006 The module SHALL have port alloc_tag, output, TAG_W bits: head tag, show-ahead, valid when alloc_valid=1.
REQ-007 The module SHALL have port alloc_valid, output, 1 bit: FIFO not empty; the dispatcher stalls when 0.
REQ-008 The module SHALL have port free_valid, input, 1 bit: retire bus returns a tag (valid and tagged instruction).
REQ-009 The module SHALL have port free_tag, input, TAG_W bits: tag being returned (retire rd_tag).
REQ-010 The module SHALL have port flush, input, 1 bit: retire-bus flush; restore the original state.
REQ-011 The module SHALL have port tag_count, output, TAG_W+1 bits: number of free tags held, 0..DEPTH.
REQ-012 The module SHALL have port full, output, 1 bit: tag_count == DEPTH.
REQ-013 The module SHALL have port overflow_err, output, 1 bit: sticky; set by a push while full.
REQ-014 The module SHALL have port underflow_err, output, 1 bit: sticky; set by alloc_req while empty.

Function
REQ-015 Storage SHALL be DEPTH entries of TAG_W bits, with rd_ptr and wr_ptr each TAG_W+1 bits (MSB = wrap bit).
REQ-016 Empty SHALL be defined as rd_ptr == wr_ptr; full SHALL be defined as equal low bits and differing MSBs.
REQ-017 tag_count SHALL equal wr_ptr - rd_ptr, modulo 2**(TAG_W+1).
REQ-018 alloc_tag SHALL be combinationally mem[rd_ptr[TAG_W-1:0]], with zero-cycle read latency.
REQ-019 Pop: when alloc_req=1 and alloc_valid=1, rd_ptr SHALL increment by 1 at the next edge.
REQ-020 Push: when free_valid=1 and full=0, mem[wr_ptr] SHALL be written with free_tag and wr_ptr SHALL increment by 1 at the next edge.
REQ-021 Simultaneous pop and push when neither empty nor full SHALL both proceed, leaving tag_count unchanged.
REQ-022 Push to an empty FIFO SHALL NOT bypass to alloc_tag; the returned tag becomes visible one cycle later.
REQ-023 A pop while empty SHALL be ignored (pointers hold) and SHALL set underflow_err.
REQ-024 A push while full SHALL be dropped, even with a simultaneous pop, and SHALL set overflow_err.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 in the low bits, toggling the MSB.
REQ-026 Flush SHALL have the highest priority: at the next edge, mem[i]=i for all i, rd_ptr=0, and wr_ptr=DEPTH (MSB=1, low bits 0).
REQ-027 Any pop or push coinciding with flush SHALL be discarded.
REQ-028 Flush SHALL NOT clear overflow_err or underflow_err.
REQ-029 The module SHALL perform no duplicate-tag checking; correctness relies on the ROB returning each tag once.

Reset
REQ-030 While rst=1, state SHALL immediately be: mem[i]=i, rd_ptr=0, wr_ptr=DEPTH, overflow_err=0, underflow_err=0.
REQ-031 Output values during and after reset SHALL be: alloc_tag=0, alloc_valid=1, full=1, tag_count=64.
REQ-032 Reset asserted mid-operation SHALL abandon all pending pops and pushes with no partial update.

Verification
REQ-033 Scenario: after reset, 3 cycles of alloc_req -> alloc_tag sequence 0,1,2; tag_count reaches 61; full=0.
REQ-034 Scenario: drain 64 pops -> alloc_valid=0, tag_count=0; one further pop -> underflow_err=1, pointers unchanged.
REQ-035 Scenario: after draining, push tag 5 -> alloc_valid stays 0 in the same cycle; next cycle alloc_valid=1, alloc_tag=5.
REQ-036 Scenario: from reset, push 9 with no pop -> dropped, overflow_err=1; the same push concurrent with a pop -> also dropped, tag_count=63.
REQ-037 Scenario: 70 pops interleaved with 70 pushes of tags returned in permuted order -> tags come back in FIFO push order across the wrap point; tag_count is never out of range.
REQ-038 Scenario: pop 10 tags, then assert flush together with alloc_req and free_valid -> next cycle tag_count=64, alloc_tag=0, and the following pops yield 0,1,2.
